// File: rtl/cmd_seq_pkg.sv
// cmd_seq_pkg: FSM states, input-decode codes and frame length (CMD_SEQ_GEN_PARITY_EN adds a parity bit)
package cmd_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [2:0] OP_DIRECT = 3'b001;
  localparam logic [2:0] OP_INVERT = 3'b010;
  localparam logic [2:0] OP_DIFF   = 3'b100;
  function automatic int frame_len(input int cmd_w, input int cnt_w);
`ifdef CMD_SEQ_GEN_PARITY_EN
    return cmd_w + cnt_w + 1;
`else
    return cmd_w + cnt_w;
`endif
  endfunction
endpackage

// File: rtl/cmd_seq_gen_if.sv
// cmd_seq_gen_if: serial command link in, one-hot stage control and status out
interface cmd_seq_gen_if #(
  parameter int NUM_STAGES = 4,
  parameter int CMD_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  data_in;
  logic                  strobe_in;
  logic                  abort;
  logic [CMD_WIDTH-1:0]  cmd_type;
  logic [CNT_WIDTH-1:0]  clk_cnt;
  logic [NUM_STAGES-1:0] stage;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic                  parity_err;
  modport master (
    output data_in, strobe_in, abort,
    input  cmd_type, clk_cnt, stage, busy, done, overflow, parity_err
  );
  modport slave (
    input  data_in, strobe_in, abort,
    output cmd_type, clk_cnt, stage, busy, done, overflow, parity_err
  );
endinterface

// File: rtl/cmd_frame_rx.sv
// cmd_frame_rx: decodes and deserialises MSB-first strobed frames; CMD_SEQ_GEN_PARITY_EN adds an odd-parity check
module cmd_frame_rx import cmd_seq_pkg::*; #(
  parameter int          CMD_WIDTH = 8,
  parameter int          CNT_WIDTH = 16,
  parameter logic [2:0]  IN_OP     = OP_DIRECT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 data_i,
  input  logic                 strobe_i,
  output logic                 frame_vld_o,
  output logic [CMD_WIDTH-1:0] cmd_o,
  output logic [CNT_WIDTH-1:0] dur_o,
  output logic                 parity_err_o
);
  localparam int FL = frame_len(CMD_WIDTH, CNT_WIDTH);
  localparam int BW = $clog2(FL);
  logic [FL-2:0]        sh_q;
  logic [FL-1:0]        sh_d;
  logic [BW-1:0]        bit_q;
  logic                 prev_q;
  logic                 dec;
  logic                 last;
  logic                 perr;
  logic [CMD_WIDTH-1:0] cmd_d;
  logic [CNT_WIDTH-1:0] dur_d;
  always_comb begin
    dec   = IN_OP == OP_DIRECT ? data_i :
            IN_OP == OP_INVERT ? ~data_i :
            IN_OP == OP_DIFF   ? data_i ^ prev_q : data_i;
    sh_d  = {sh_q, dec};
    last  = bit_q == BW'(FL - 1);
    cmd_d = sh_d[FL-1 -: CMD_WIDTH];
`ifdef CMD_SEQ_GEN_PARITY_EN
    dur_d = sh_d[CNT_WIDTH:1];
    perr  = ~^sh_d;
`else
    dur_d = sh_d[CNT_WIDTH-1:0];
    perr  = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      sh_q         <= '0;
      bit_q        <= '0;
      prev_q       <= 1'b0;
      frame_vld_o  <= 1'b0;
      parity_err_o <= 1'b0;
      cmd_o        <= '0;
      dur_o        <= '0;
    end else begin
      frame_vld_o  <= strobe_i && last && !perr && dur_d != '0;
      parity_err_o <= strobe_i && last && perr;
      if (strobe_i) begin
        sh_q   <= sh_d[FL-2:0];
        prev_q <= data_i;
        bit_q  <= last ? '0 : bit_q + BW'(1);
      end
      if (strobe_i && last) begin
        cmd_o <= cmd_d;
        dur_o <= dur_d;
      end
    end
  end
endmodule

// File: rtl/cmd_seq_gen.sv
// cmd_seq_gen: one-deep frame buffer driving NUM_STAGES one-hot stages of D clocks each; CMD_SEQ_GEN_PARITY_EN enables frame parity
module cmd_seq_gen import cmd_seq_pkg::*; #(
  parameter int         NUM_STAGES = 4,
  parameter int         CMD_WIDTH  = 8,
  parameter int         CNT_WIDTH  = 16,
  parameter logic [2:0] IN_OP      = OP_DIRECT,
  parameter bit         OUT_INV    = 1'b0
) (
  input logic           clk,
  input logic           rst,
  cmd_seq_gen_if.slave  bus
);
  state_e                state_q;
  logic                  rx_vld, new_vld_q, pend_vld_q, busy_q, done_q, ovf_q;
  logic [CMD_WIDTH-1:0]  rx_cmd, new_cmd_q, pend_cmd_q, cmd_q;
  logic [CNT_WIDTH-1:0]  rx_dur, new_dur_q, pend_dur_q, dur_q, cnt_q;
  logic [NUM_STAGES-1:0] stage_q;
  logic                  launch, stage_end, last_stage;
  cmd_frame_rx #(.CMD_WIDTH(CMD_WIDTH), .CNT_WIDTH(CNT_WIDTH), .IN_OP(IN_OP)) u_rx (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (bus.abort),
    .data_i       (bus.data_in),
    .strobe_i     (bus.strobe_in),
    .frame_vld_o  (rx_vld),
    .cmd_o        (rx_cmd),
    .dur_o        (rx_dur),
    .parity_err_o (bus.parity_err)
  );
  assign launch     = pend_vld_q || new_vld_q;
  assign stage_end  = cnt_q == dur_q - CNT_WIDTH'(1);
  assign last_stage = stage_q[NUM_STAGES-1];
  always_ff @(posedge clk) begin
    if (rst || bus.abort) begin
      new_vld_q <= 1'b0;
      new_cmd_q <= '0;
      new_dur_q <= '0;
    end else begin
      new_vld_q <= rx_vld;
      new_cmd_q <= rx_cmd;
      new_dur_q <= rx_dur;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      stage_q    <= '0;
      cnt_q      <= '0;
      cmd_q      <= '0;
      dur_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_cmd_q <= '0;
      pend_dur_q <= '0;
    end else if (bus.abort) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stage_q    <= '0;
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q    <= launch ? RUN : IDLE;
          busy_q     <= launch;
          stage_q    <= launch ? NUM_STAGES'(1) : '0;
          cnt_q      <= '0;
          pend_vld_q <= pend_vld_q && new_vld_q;
          if (launch) begin
            cmd_q <= pend_vld_q ? pend_cmd_q : new_cmd_q;
            dur_q <= pend_vld_q ? pend_dur_q : new_dur_q;
          end
          if (new_vld_q) begin
            pend_cmd_q <= new_cmd_q;
            pend_dur_q <= new_dur_q;
          end
        end
        RUN: begin
          if (new_vld_q && pend_vld_q) ovf_q <= 1'b1;
          if (new_vld_q && !pend_vld_q) begin
            pend_vld_q <= 1'b1;
            pend_cmd_q <= new_cmd_q;
            pend_dur_q <= new_dur_q;
          end
          cnt_q <= stage_end ? '0 : cnt_q + CNT_WIDTH'(1);
          if (stage_end) begin
            stage_q <= last_stage ? '0 : stage_q << 1;
            state_q <= last_stage ? DONE : RUN;
            busy_q  <= !last_stage;
            done_q  <= last_stage;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.cmd_type = cmd_q;
  assign bus.clk_cnt  = cnt_q;
  assign bus.stage    = stage_q ^ {NUM_STAGES{OUT_INV}};
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_cmd_seq_gen.sv
// tb_cmd_seq_gen: scoreboard bench for cmd_seq_gen (default DUT plus a 2-stage differential, inverted-output DUT)
module tb_cmd_seq_gen;
  localparam int CW = 8;
  localparam int NW = 16;
`ifdef CMD_SEQ_GEN_PARITY_EN
  localparam int FL = CW + NW + 1;
`else
  localparam int FL = CW + NW;
`endif
  typedef struct packed {logic [CW-1:0] cmd; logic [NW-1:0] dur;} exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_prev = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  cmd_seq_gen_if #(.NUM_STAGES(4), .CMD_WIDTH(CW), .CNT_WIDTH(NW)) a ();
  cmd_seq_gen_if #(.NUM_STAGES(2), .CMD_WIDTH(CW), .CNT_WIDTH(NW)) b ();

  cmd_seq_gen #(.NUM_STAGES(4), .CMD_WIDTH(CW), .CNT_WIDTH(NW), .IN_OP(3'b001), .OUT_INV(1'b0)) u_a (
    .clk(clk), .rst(rst), .bus(a)
  );
  cmd_seq_gen #(.NUM_STAGES(2), .CMD_WIDTH(CW), .CNT_WIDTH(NW), .IN_OP(3'b100), .OUT_INV(1'b1)) u_b (
    .clk(clk), .rst(rst), .bus(b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit reached, exp finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FL-1:0] mk(input logic [CW-1:0] c, input logic [NW-1:0] d);
`ifdef CMD_SEQ_GEN_PARITY_EN
    return {c, d, ~(^{c, d})};
`else
    return {c, d};
`endif
  endfunction

  // to_b selects the differential DUT; its raw line bit is decoded bit XOR previous raw bit
  task automatic send(input bit to_b, input logic [FL-1:0] f);
    for (int i = FL - 1; i >= 0; i--) begin
      if (to_b) begin
        b.data_in = f[i] ^ b_prev;
        b_prev = f[i] ^ b_prev;
        b.strobe_in = 1'b1;
      end else begin
        a.data_in = f[i];
        a.strobe_in = 1'b1;
      end
      tick();
    end
    a.strobe_in = 1'b0;
    a.data_in = 1'b0;
    b.strobe_in = 1'b0;
    b.data_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a.data_in = 0; a.strobe_in = 0; a.abort = 0;
    b.data_in = 0; b.strobe_in = 0; b.abort = 0;
    b_prev = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if (a.cmd_type !== 8'h00) begin errors++; $display("FAIL rst_cmd_type: got %h exp 00", a.cmd_type); end
    checks++; if (a.clk_cnt !== 16'd0) begin errors++; $display("FAIL rst_clk_cnt: got %0d exp 0", a.clk_cnt); end
    checks++; if (a.stage !== 4'b0000) begin errors++; $display("FAIL rst_stage: got %b exp 0000", a.stage); end
    checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", a.busy); end
    checks++; if (a.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b exp 0", a.done); end
    checks++; if (a.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b exp 0", a.overflow); end
    checks++; if (a.parity_err !== 1'b0) begin errors++; $display("FAIL rst_parity_err: got %b exp 0", a.parity_err); end
    checks++; if (b.stage !== 2'b11) begin errors++; $display("FAIL rst_stage_inv: got %b exp 11", b.stage); end
  endtask

  task automatic test_basic();
    exp_t e;
    logic [3:0] oh;
    sb.push_back({8'hA5, 16'd3});
    send(1'b0, mk(8'hA5, 16'd3));
    tick();
    checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL basic_latency: got busy=%b exp 0 at E+1", a.busy); end
    tick();
    e = sb.pop_front();
    checks++; if (a.cmd_type !== e.cmd) begin errors++; $display("FAIL basic_cmd_type: got %h exp %h", a.cmd_type, e.cmd); end
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < int'(e.dur); j++) begin
        oh = 4'b0001 << k;
        checks++;
        if ({a.stage, a.clk_cnt, a.busy} !== {oh, 16'(j), 1'b1}) begin
          errors++;
          $display("FAIL basic_seq k=%0d j=%0d: got stage=%b cnt=%0d busy=%b exp stage=%b cnt=%0d busy=1", k, j, a.stage, a.clk_cnt, a.busy, oh, j);
        end
        tick();
      end
    end
    checks++; if ({a.done, a.busy, a.stage} !== 6'b100000) begin errors++; $display("FAIL basic_done: got done=%b busy=%b stage=%b exp 1 0 0000", a.done, a.busy, a.stage); end
    tick();
    checks++; if (a.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b exp 0", a.done); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int l0, n;
    sb.push_back({8'h11, 16'd100});
    send(1'b0, mk(8'h11, 16'd100));
    tick(); tick();
    e = sb.pop_front();
    l0 = cyc;
    checks++; if ({a.busy, a.cmd_type} !== {1'b1, e.cmd}) begin errors++; $display("FAIL b2b_launch1: got busy=%b cmd=%h exp 1 %h", a.busy, a.cmd_type, e.cmd); end
    sb.push_back({8'h22, 16'd100});
    send(1'b0, mk(8'h22, 16'd100));
    send(1'b0, mk(8'h33, 16'd100));
    tick(); tick();
    checks++; if (a.overflow !== 1'b1) begin errors++; $display("FAIL b2b_overflow_set: got %b exp 1", a.overflow); end
    n = 0;
    while (a.done !== 1'b1 && n < 500) begin tick(); n++; end
    checks++; if (a.done !== 1'b1 || cyc - l0 != 400) begin errors++; $display("FAIL b2b_done1: got done=%b after %0d cycles exp 1 after 400", a.done, cyc - l0); end
    tick();
    e = sb.pop_front();
    l0 = cyc;
    checks++; if ({a.busy, a.stage, a.cmd_type} !== {1'b1, 4'b0001, e.cmd}) begin errors++; $display("FAIL b2b_launch2: got busy=%b stage=%b cmd=%h exp 1 0001 %h", a.busy, a.stage, a.cmd_type, e.cmd); end
    n = 0;
    while (a.done !== 1'b1 && n < 500) begin tick(); n++; end
    checks++; if (a.done !== 1'b1 || cyc - l0 != 400) begin errors++; $display("FAIL b2b_done2: got done=%b after %0d cycles exp 1 after 400", a.done, cyc - l0); end
    repeat (2) tick();
    checks++; if ({a.busy, a.cmd_type} !== {1'b0, 8'h22}) begin errors++; $display("FAIL b2b_third_dropped: got busy=%b cmd=%h exp 0 22", a.busy, a.cmd_type); end
    checks++; if (a.overflow !== 1'b1) begin errors++; $display("FAIL b2b_overflow_sticky: got %b exp 1", a.overflow); end
    rst = 1'b1; b_prev = 1'b0;
    tick();
    rst = 1'b0;
    checks++; if (a.overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow_rst: got %b exp 0", a.overflow); end
  endtask

  task automatic test_abort();
    exp_t e;
    int l0, n;
    logic seen;
    sb.push_back({8'h5A, 16'd10});
    send(1'b0, mk(8'h5A, 16'd10));
    tick(); tick();
    e = sb.pop_front();
    l0 = cyc;
    checks++; if (a.cmd_type !== e.cmd) begin errors++; $display("FAIL abort_launch: got %h exp %h", a.cmd_type, e.cmd); end
    send(1'b0, mk(8'h77, 16'd10));
    while (cyc < l0 + 27) tick();
    checks++; if (a.stage !== 4'b0100) begin errors++; $display("FAIL abort_pre_stage: got %b exp 0100", a.stage); end
    a.abort = 1'b1;
    tick();
    a.abort = 1'b0;
    checks++; if ({a.busy, a.done, a.stage, a.clk_cnt} !== 22'd0) begin errors++; $display("FAIL abort_idle: got busy=%b done=%b stage=%b cnt=%0d exp all 0", a.busy, a.done, a.stage, a.clk_cnt); end
    checks++; if (a.cmd_type !== 8'h5A) begin errors++; $display("FAIL abort_cmd_hold: got %h exp 5a", a.cmd_type); end
    seen = 1'b0;
    repeat (30) begin tick(); seen = seen | a.busy | a.done; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_pending_cleared: got activity=%b exp 0", seen); end
    for (int i = 0; i < 7; i++) begin a.data_in = 1'b1; a.strobe_in = 1'b1; tick(); end
    a.strobe_in = 1'b0;
    a.abort = 1'b1;
    tick();
    a.abort = 1'b0;
    sb.push_back({8'h96, 16'd2});
    send(1'b0, mk(8'h96, 16'd2));
    tick(); tick();
    e = sb.pop_front();
    checks++; if ({a.busy, a.cmd_type} !== {1'b1, e.cmd}) begin errors++; $display("FAIL abort_rx_realign: got busy=%b cmd=%h exp 1 %h", a.busy, a.cmd_type, e.cmd); end
    n = 0;
    while (a.done !== 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (n != 8) begin errors++; $display("FAIL abort_rx_seq_len: got done after %0d cycles exp 8", n); end
    tick();
  endtask

  task automatic test_diff();
    exp_t e;
    logic [1:0] oh;
    logic seen;
    sb.push_back({8'h3C, 16'd2});
    send(1'b1, mk(8'h3C, 16'd2));
    tick();
    checks++; if (b.busy !== 1'b0) begin errors++; $display("FAIL diff_latency: got busy=%b exp 0", b.busy); end
    tick();
    e = sb.pop_front();
    checks++; if (b.cmd_type !== e.cmd) begin errors++; $display("FAIL diff_cmd_type: got %h exp %h", b.cmd_type, e.cmd); end
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < int'(e.dur); j++) begin
        oh = ~(2'b01 << k);
        checks++;
        if ({b.stage, b.clk_cnt, b.busy} !== {oh, 16'(j), 1'b1}) begin
          errors++;
          $display("FAIL diff_seq k=%0d j=%0d: got stage=%b cnt=%0d busy=%b exp stage=%b cnt=%0d busy=1", k, j, b.stage, b.clk_cnt, b.busy, oh, j);
        end
        tick();
      end
    end
    checks++; if ({b.done, b.busy, b.stage} !== 4'b1011) begin errors++; $display("FAIL diff_done: got done=%b busy=%b stage=%b exp 1 0 11", b.done, b.busy, b.stage); end
    send(1'b1, mk(8'h12, 16'd0));
    seen = 1'b0;
    repeat (10) begin tick(); seen = seen | b.busy | b.done; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL diff_zero_dur: got activity=%b exp 0", seen); end
    checks++; if (b.cmd_type !== 8'h3C) begin errors++; $display("FAIL diff_zero_dur_cmd: got %h exp 3c", b.cmd_type); end
  endtask

  task automatic test_parity();
    exp_t e;
    logic [FL-1:0] f;
    logic seen;
    int n;
    f = mk(8'h4B, 16'd2);
`ifdef CMD_SEQ_GEN_PARITY_EN
    f[0] = ~f[0];
    send(1'b0, f);
    checks++; if (a.parity_err !== 1'b1) begin errors++; $display("FAIL parity_err_pulse: got %b exp 1", a.parity_err); end
    tick();
    checks++; if (a.parity_err !== 1'b0) begin errors++; $display("FAIL parity_err_width: got %b exp 0", a.parity_err); end
    seen = 1'b0;
    repeat (10) begin tick(); seen = seen | a.busy | a.done | a.overflow; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL parity_no_run: got activity=%b exp 0", seen); end
    f = mk(8'h4B, 16'd2);
`endif
    sb.push_back({8'h4B, 16'd2});
    send(1'b0, f);
    checks++; if (a.parity_err !== 1'b0) begin errors++; $display("FAIL parity_ok_no_err: got %b exp 0", a.parity_err); end
    tick(); tick();
    e = sb.pop_front();
    checks++; if ({a.busy, a.cmd_type} !== {1'b1, e.cmd}) begin errors++; $display("FAIL parity_ok_run: got busy=%b cmd=%h exp 1 %h", a.busy, a.cmd_type, e.cmd); end
    n = 0;
    while (a.done !== 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (n != 8) begin errors++; $display("FAIL parity_ok_len: got done after %0d cycles exp 8", n); end
    tick();
  endtask

  task automatic test_rst();
    exp_t e;
    logic [3:0] oh;
    for (int i = 0; i < 10; i++) begin a.data_in = i[0]; a.strobe_in = 1'b1; tick(); end
    a.strobe_in = 1'b0;
    rst = 1'b1; b_prev = 1'b0;
    tick();
    rst = 1'b0;
    checks++; if ({a.cmd_type, a.clk_cnt, a.stage, a.busy, a.done, a.overflow} !== 31'd0) begin errors++; $display("FAIL rst_mid_frame: got cmd=%h cnt=%0d stage=%b busy=%b exp all 0", a.cmd_type, a.clk_cnt, a.stage, a.busy); end
    sb.push_back({8'h5C, 16'd50});
    send(1'b0, mk(8'h5C, 16'd50));
    tick(); tick();
    e = sb.pop_front();
    checks++; if ({a.busy, a.cmd_type} !== {1'b1, e.cmd}) begin errors++; $display("FAIL rst_pre_run: got busy=%b cmd=%h exp 1 %h", a.busy, a.cmd_type, e.cmd); end
    repeat (20) tick();
    rst = 1'b1; b_prev = 1'b0;
    tick();
    rst = 1'b0;
    checks++; if ({a.cmd_type, a.clk_cnt, a.stage, a.busy, a.done, a.overflow} !== 31'd0) begin errors++; $display("FAIL rst_mid_run: got cmd=%h cnt=%0d stage=%b busy=%b exp all 0", a.cmd_type, a.clk_cnt, a.stage, a.busy); end
    checks++; if (b.stage !== 2'b11) begin errors++; $display("FAIL rst_mid_run_inv: got %b exp 11", b.stage); end
    sb.push_back({8'hC3, 16'd1});
    send(1'b0, mk(8'hC3, 16'd1));
    tick(); tick();
    e = sb.pop_front();
    checks++; if (a.cmd_type !== e.cmd) begin errors++; $display("FAIL rst_next_frame: got %h exp %h", a.cmd_type, e.cmd); end
    for (int k = 0; k < 4; k++) begin
      oh = 4'b0001 << k;
      checks++; if ({a.stage, a.clk_cnt} !== {oh, 16'd0}) begin errors++; $display("FAIL rst_next_seq k=%0d: got stage=%b cnt=%0d exp %b 0", k, a.stage, a.clk_cnt, oh); end
      tick();
    end
    checks++; if (a.done !== 1'b1) begin errors++; $display("FAIL rst_next_done: got %b exp 1", a.done); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_diff();
    test_parity();
    test_rst();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries exp 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
